sram_loader: RTL and testbench

SRAM_LOADER -- requirements
Module: sram_loader

---
 rtl/sram_loader.sv | 147 ++++++++++++++
 tb/tb_sram_loader.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_loader.sv
// Purpose: copies an image or a coefficient set from SRAM into a halfword-indexed buffer (SRAM_LOADER_CKSUM_EN adds a running halfword checksum).
// Latency: 3+RD_LAT cycles per 32-bit word; 1+N*(3+RD_LAT) cycles from accepted start to the done pulse.
// Backpressure: none; start is ignored while busy, and abort returns to IDLE on the next edge.
module sram_loader #(
    parameter int ADDR_W    = 16,
    parameter int IMG_WORDS = 32,
    parameter int WGT_WORDS = 512,
    parameter int RD_LAT    = 1,
    localparam int MAX_WORDS = (IMG_WORDS > WGT_WORDS) ? IMG_WORDS : WGT_WORDS,
    localparam int IDX_W     = $clog2(2 * MAX_WORDS)
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    input  logic              mode,
    input  logic [6:0]        coef_select,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              abort,
    input  logic [31:0]       read_data,
    output logic              read,
    output logic [ADDR_W-1:0] address,
    output logic              wr_en,
    output logic [IDX_W-1:0]  wr_idx,
    output logic [15:0]       wr_data,
    output logic              busy,
    output logic              done,
    output logic [15:0]       checksum
);

    localparam int K_W = (IDX_W > 1) ? IDX_W - 1 : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        WR_LO = 3'd3,
        WR_HI = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t            st;
    state_t            nxt;
    logic [K_W-1:0]    k;
    logic [K_W-1:0]    last_k;
    logic              mode_q;
    logic [1:0]        wait_cnt;
    logic [15:0]       cap_hi;
    logic              accept;
    logic [ADDR_W-1:0] first_addr;

    assign accept = (st == IDLE) && start && !abort;
    assign last_k = mode_q ? K_W'(WGT_WORDS - 1) : K_W'(IMG_WORDS - 1);

    // Region start for the load being accepted; coefficient sets are packed back to back.
    assign first_addr = base_addr
                      + (mode ? ADDR_W'(coef_select) * ADDR_W'(WGT_WORDS) : '0);

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            st <= IDLE;
        end else begin
            st <= nxt;
        end
    end

    // Next-state logic; abort overrides every transition out of a non-IDLE state.
    always_comb begin
        nxt = st;
        case (st)
            IDLE:    if (start && !abort) nxt = ISSUE;
            ISSUE:   nxt = WAIT;
            WAIT:    if (wait_cnt == 2'(RD_LAT - 1)) nxt = WR_LO;
            WR_LO:   nxt = WR_HI;
            WR_HI:   nxt = (k == last_k) ? DONE : ISSUE;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
        if (st != IDLE && abort) nxt = IDLE;
    end

    // Strobes decoded purely from the current state.
    always_comb begin
        read  = 1'b0;
        wr_en = 1'b0;
        done  = 1'b0;
        busy  = 1'b1;
        case (st)
            IDLE:         busy  = 1'b0;
            ISSUE:        read  = 1'b1;
            WR_LO, WR_HI: wr_en = 1'b1;
            DONE:         done  = 1'b1;
            default:      busy  = 1'b1;
        endcase
    end

    // Datapath: word counter, read latency counter, address and write port registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            k        <= '0;
            mode_q   <= 1'b0;
            wait_cnt <= '0;
            cap_hi   <= '0;
            address  <= '0;
            wr_idx   <= '0;
            wr_data  <= '0;
        end else begin
            wait_cnt <= (st == WAIT) ? wait_cnt + 2'd1 : 2'd0;
            if (accept) begin
                k       <= '0;
                mode_q  <= mode;
                address <= first_addr;
            end
            // Address holds between reads, so the next word is simply the previous plus one.
            if (st == WR_HI && nxt == ISSUE) begin
                k       <= k + K_W'(1);
                address <= address + ADDR_W'(1);
            end
            // Low half goes straight to the write port; high half waits one cycle.
            if (st == WAIT && nxt == WR_LO) begin
                cap_hi  <= read_data[31:16];
                wr_data <= read_data[15:0];
                wr_idx  <= {k, 1'b0};
            end
            if (st == WR_LO && nxt == WR_HI) begin
                wr_data <= cap_hi;
                wr_idx  <= {k, 1'b1};
            end
        end
    end

`ifdef SRAM_LOADER_CKSUM_EN
    // Running modulo-2^16 sum of every halfword written during the current load.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            checksum <= '0;
        end else if (accept) begin
            checksum <= '0;
        end else if (wr_en) begin
            checksum <= checksum + wr_data;
        end
    end
`else
    assign checksum = 16'h0000;
`endif

endmodule

// File: tb/tb_sram_loader.sv
// Purpose: randomized self-checking bench for sram_loader against an address/data list model.
// Latency: checks the 1+N*(3+RD_LAT) done latency and every read and write of each load.
// Backpressure: exercises start-while-busy, start+abort in IDLE, mid-load abort and mid-load reset.
module tb_sram_loader;

    localparam int ADDR_W    = 16;
    localparam int IMG_WORDS = 32;
    localparam int WGT_WORDS = 512;
    localparam int RD_LAT    = 1;
    localparam int MAX_WORDS = (IMG_WORDS > WGT_WORDS) ? IMG_WORDS : WGT_WORDS;
    localparam int IDX_W     = $clog2(2 * MAX_WORDS);

    logic              clk;
    logic              n_rst;
    logic              start;
    logic              mode;
    logic [6:0]        coef_select;
    logic [ADDR_W-1:0] base_addr;
    logic              abort;
    logic [31:0]       read_data;
    logic              read;
    logic [ADDR_W-1:0] address;
    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [15:0]       wr_data;
    logic              busy;
    logic              done;
    logic [15:0]       checksum;

    sram_loader #(
        .ADDR_W    (ADDR_W),
        .IMG_WORDS (IMG_WORDS),
        .WGT_WORDS (WGT_WORDS),
        .RD_LAT    (RD_LAT)
    ) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .start       (start),
        .mode        (mode),
        .coef_select (coef_select),
        .base_addr   (base_addr),
        .abort       (abort),
        .read_data   (read_data),
        .read        (read),
        .address     (address),
        .wr_en       (wr_en),
        .wr_idx      (wr_idx),
        .wr_data     (wr_data),
        .busy        (busy),
        .done        (done),
        .checksum    (checksum)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- SRAM model: content is a function of the address ----------------
    logic [15:0] salt, salt2;
    logic        use_fixed;
    logic [31:0] fixed_word;
    int          cyc;
    logic [ADDR_W-1:0] p_addr [RD_LAT];
    logic              p_vld  [RD_LAT];

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        if (use_fixed) return fixed_word;
        return {16'(a * 3 + salt), a ^ salt2};
    endfunction

    initial cyc = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        p_vld[0]  <= read;
        p_addr[0] <= address;
        for (int i = 1; i < RD_LAT; i++) begin
            p_vld[i]  <= p_vld[i-1];
            p_addr[i] <= p_addr[i-1];
        end
    end

    // Data is only meaningful RD_LAT cycles after the strobe; junk otherwise.
    assign read_data = p_vld[RD_LAT-1]
                     ? (use_fixed ? fixed_word
                                  : {16'(p_addr[RD_LAT-1] * 3 + salt), p_addr[RD_LAT-1] ^ salt2})
                     : {cyc[15:0], ~cyc[15:0]};

    // ---------------- Monitor ----------------
    logic [15:0] obs_addr [$];
    logic [15:0] obs_widx [$];
    logic [15:0] obs_wdat [$];
    int          done_cnt;
    int          done_cyc;

    always @(negedge clk) begin
        if (read) obs_addr.push_back(address);
        if (wr_en) begin
            obs_widx.push_back(16'(wr_idx));
            obs_wdat.push_back(wr_data);
        end
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
    end

    task automatic clear_obs();
        obs_addr.delete();
        obs_widx.delete();
        obs_wdat.delete();
        done_cnt = 0;
    endtask

    // ---------------- Checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] exp_addr(input bit m, input logic [6:0] c,
                                             input logic [15:0] b, input int kk);
        return 16'(int'(b) + (m ? int'(c) * WGT_WORDS : 0) + kk);
    endfunction

    int last_lat;

    // One complete load: drive start, wait for done, compare every read and write to the model.
    task automatic run_load(input bit m, input logic [6:0] c, input logic [15:0] b,
                            input bit fixed, input logic [31:0] fw, input bit poke);
        int n, s, bound;
        logic [31:0] w, got;
        logic [15:0] half, sum;
        clear_obs();
        use_fixed = fixed;
        fixed_word = fw;
        n = m ? WGT_WORDS : IMG_WORDS;
        bound = 1 + n * (3 + RD_LAT) + 20;
        start = 1'b1; mode = m; coef_select = c; base_addr = b;
        @(negedge clk);
        s = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        mode = 1'($urandom); coef_select = 7'($urandom); base_addr = 16'($urandom);
        check_eq("busy_after_start", 32'(busy), 32'd1);
        for (int i = 0; i < bound && done_cnt == 0; i++) begin
            @(posedge clk); #1;
            if (poke && i == 5) begin
                check_eq("busy_mid_load", 32'(busy), 32'd1);
                start = 1'b1; mode = ~m; base_addr = 16'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check_eq("done_count", 32'(done_cnt), 32'd1);
        last_lat = done_cyc - s;
        check_eq("done_latency", 32'(last_lat), 32'(1 + n * (3 + RD_LAT)));
        check_eq("busy_after_done", 32'(busy), 32'd0);
        check_eq("read_count", 32'(obs_addr.size()), 32'(n));
        check_eq("write_count", 32'(obs_widx.size()), 32'(2 * n));
        sum = 16'h0000;
        for (int kk = 0; kk < n; kk++) begin
            got = (kk < obs_addr.size()) ? 32'(obs_addr[kk]) : 32'hFFFF_FFFF;
            check_eq("rd_addr", got, 32'(exp_addr(m, c, b, kk)));
            w = mem_word(exp_addr(m, c, b, kk));
            for (int h = 0; h < 2; h++) begin
                half = h ? w[31:16] : w[15:0];
                sum = sum + half;
                got = (2*kk+h < obs_widx.size()) ? 32'(obs_widx[2*kk+h]) : 32'hFFFF_FFFF;
                check_eq("wr_idx", got, 32'(2 * kk + h));
                got = (2*kk+h < obs_wdat.size()) ? 32'(obs_wdat[2*kk+h]) : 32'hFFFF_FFFF;
                check_eq("wr_data", got, 32'(half));
            end
        end
`ifdef SRAM_LOADER_CKSUM_EN
        check_eq("checksum", 32'(checksum), 32'(sum));
`else
        check_eq("checksum", 32'(checksum), 32'd0);
`endif
    endtask

    // ---------------- Stimulus ----------------
    initial begin
        n_rst = 1'b0; start = 1'b0; mode = 1'b0; coef_select = '0; base_addr = '0; abort = 1'b0;
        use_fixed = 1'b0; fixed_word = '0; done_cnt = 0; done_cyc = 0; last_lat = 0;
        salt = 16'($urandom); salt2 = 16'($urandom);
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_read", 32'(read), 32'd0);
        check_eq("rst_address", 32'(address), 32'd0);
        check_eq("rst_wr_en", 32'(wr_en), 32'd0);
        check_eq("rst_wr_idx", 32'(wr_idx), 32'd0);
        check_eq("rst_wr_data", 32'(wr_data), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_checksum", 32'(checksum), 32'd0);
        n_rst = 1'b1;
        @(posedge clk); #1;

        // Image load with a constant word.
        run_load(1'b0, 7'd0, 16'h0100, 1'b1, 32'h0002_0001, 1'b0);
        check_eq("img_first_addr", 32'(obs_addr[0]), 32'h0100);
        check_eq("img_last_addr", 32'(obs_addr[obs_addr.size()-1]), 32'h011F);
        check_eq("img_lat_129", 32'(last_lat), 32'd129);
        check_eq("img_wdat0", 32'(obs_wdat[0]), 32'h0001);
        check_eq("img_wdat1", 32'(obs_wdat[1]), 32'h0002);

        // Weight set 3.
        run_load(1'b1, 7'd3, 16'h1000, 1'b0, 32'h0, 1'b0);
        check_eq("wgt_first_addr", 32'(obs_addr[0]), 32'h1600);
        check_eq("wgt_last_addr", 32'(obs_addr[obs_addr.size()-1]), 32'h17FF);
        check_eq("wgt_last_idx", 32'(obs_widx[obs_widx.size()-1]), 32'd1023);

        // Address wrap past 2^16.
        run_load(1'b1, 7'd127, 16'hFFFF, 1'b0, 32'h0, 1'b0);
        check_eq("wrap_first_addr", 32'(obs_addr[0]), 32'hFDFF);

        // Randomized loads; the second one sees a start pulse while busy.
        for (int t = 0; t < 4; t++) begin
            salt = 16'($urandom);
            run_load(1'b0, 7'($urandom), 16'($urandom), 1'b0, 32'h0, t == 1);
        end
        run_load(1'b1, 7'($urandom), 16'($urandom), 1'b0, 32'h0, 1'b1);

        // Abort during the third WAIT.
        clear_obs();
        use_fixed = 1'b0;
        start = 1'b1; mode = 1'b0; base_addr = 16'($urandom);
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 40 && obs_addr.size() < 3; i++) begin
            @(posedge clk); #1;
        end
        check_eq("abort_reads_reached", 32'(obs_addr.size()), 32'd3);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_read", 32'(read), 32'd0);
        check_eq("abort_wr_en", 32'(wr_en), 32'd0);
        check_eq("abort_done", 32'(done), 32'd0);
        repeat (20) @(posedge clk);
        #1;
        check_eq("abort_total_reads", 32'(obs_addr.size()), 32'd3);
        check_eq("abort_total_writes", 32'(obs_widx.size()), 32'd4);
        check_eq("abort_no_done", 32'(done_cnt), 32'd0);

        // start and abort together in IDLE: not accepted.
        clear_obs();
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        check_eq("start_abort_busy", 32'(busy), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        check_eq("start_abort_no_read", 32'(obs_addr.size()), 32'd0);

        // Checksum wrap: 64 halfwords of 0x8000 sum to zero.
        run_load(1'b0, 7'd0, 16'h0200, 1'b1, 32'h8000_8000, 1'b0);
        check_eq("cksum_wrap_zero", 32'(checksum), 32'd0);

        // Reset in the middle of a load.
        clear_obs();
        use_fixed = 1'b0;
        start = 1'b1; mode = 1'b0; base_addr = 16'($urandom);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (30) @(posedge clk);
        #2;
        n_rst = 1'b0;
        #1;
        check_eq("midrst_busy", 32'(busy), 32'd0);
        check_eq("midrst_read", 32'(read), 32'd0);
        check_eq("midrst_wr_en", 32'(wr_en), 32'd0);
        check_eq("midrst_address", 32'(address), 32'd0);
        check_eq("midrst_wr_data", 32'(wr_data), 32'd0);
        check_eq("midrst_checksum", 32'(checksum), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        n_rst = 1'b1;
        clear_obs();
        repeat (150) @(posedge clk);
        #1;
        check_eq("midrst_no_done", 32'(done_cnt), 32'd0);
        check_eq("midrst_no_read", 32'(obs_addr.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
